button_event_port: RTL
======================

Name: button_event_port

Overview:
- Memory-mapped input responder for the blackjack processor's button read at data address 4096.
- Synchronises and debounces BTNU/BTND/BTNL/BTNR, and turns each debounced press into an event code.
- Queues events in a small FIFO and returns one event per processor load, popping on read, so presses are neither missed nor double-counted.
- Sits between the board buttons and the q_dmem read mux in the top-level wrapper.

Parameters:
- DEBOUNCE_CYCLES, 250000: consecutive stable cycles before a level change is accepted (10 ms at 25 MHz); minimum 1.
- FIFO_DEPTH, 4: event queue entries; power of two, minimum 2.
- IO_ADDR, 32'd4096: data address that is decoded as the event port.

Ports:
- clock  in  1  system clock (25 MHz domain); all state on posedge.
- reset  in  1  synchronous, active-high reset.
- btn_in  in  4  raw buttons {BTNR, BTNL, BTND, BTNU} = bits [3:0] as {3,2,1,0}; asynchronous to clock.
- io_addr  in  32  processor data address (address_dmem).
- io_wren  in  1  processor store enable (wren).
- io_hit  out  1  combinational: io_addr == IO_ADDR and io_wren == 0.
- io_rdata  out  32  read data for the q_dmem mux; 0 when io_hit == 0.
- btn_level  out  4  debounced button levels.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current queue occupancy.

Behaviour:
- Reset values, forced in the cycle reset is high regardless of other inputs:
  - synchronisers, debounce counters, btn_level and pending bits are 0.
  - FIFO is empty: fifo_count = 0, read/write pointers 0.
  - hold register and hit_d flag are 0.
  - io_rdata is 0.
- Synchronisation: two flops per button, so btn_in reaches the debouncer after 2 cycles.
- Debounce, per button:
  - While the synced value equals btn_level, the counter is 0.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 while still differing, btn_level toggles and the counter clears.
  - Any return to equality clears the counter.
- Press event: a btn_level 0->1 transition sets pending[i]. A release generates no event.
- Event codes: BTNU=1, BTND=2, BTNL=3, BTNR=4. An empty-queue read returns 0. Code 1/2 semantics match the existing BTNU/BTND read convention.
- Enqueue arbiter:
  - At most one push per cycle.
  - Pushes the lowest-index pending bit (U>D>L>R) when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
  - That pending bit clears in the same cycle.
- Full queue: pending bits stay set, so no event is lost. A second press of the same button while its pending bit is already set is coalesced (dropped).
- Read handshake:
  - hit_d registers io_hit each cycle.
  - The first hit cycle (io_hit & ~hit_d) is the access edge. On it, io_rdata = FIFO head (0 if empty), the head is copied into the hold register, and the FIFO pops if non-empty.
  - Later consecutive hit cycles (stall) present the hold register and do not pop.
  - A new pop requires io_hit to drop for at least one cycle.
- Simultaneous push and pop: occupancy unchanged, pointers both advance. Push into an empty FIFO in the same cycle as an access edge: the read returns 0, and the pushed event is available on the next access.
- Pointers wrap modulo FIFO_DEPTH. fifo_count never exceeds FIFO_DEPTH.
- Stores to IO_ADDR are ignored: io_hit = 0, no pop.
- Reset mid-press: the queue and pending bits are cleared. A button held through reset re-debounces from level 0 and generates exactly one new event after DEBOUNCE_CYCLES+2 cycles.

Optional Feature:
- Macro: BTN_EVENT_STATUS_EN.
- Defined:
  - A second address, IO_ADDR+1, decodes as a status read with the same edge/hold rules.
  - Returned word: {16'b0, overflow, 7'b0, fifo_count zero-extended to 4 bits, btn_level}.
  - overflow is sticky. It is set when a press is coalesced, and cleared on the status access edge. If a coalesce happens in the same cycle as that access edge, set wins.
  - A status read never pops the queue.
- Undefined: IO_ADDR+1 is not decoded, there is no overflow logic, and io_hit covers IO_ADDR only.

Test Plan (bench uses DEBOUNCE_CYCLES=4, FIFO_DEPTH=4):
- Reset, then read IO_ADDR with no presses -> io_rdata=0, fifo_count=0.
- Hold btn_in=4'b0001 for 10 cycles, then read -> fifo_count goes 0->1 at cycle 7; io_rdata=1; fifo_count=0 after the access edge.
- Bounce BTND 1-0-1-0 every 2 cycles, then hold at 1 for 6 cycles -> exactly one event; read returns 2.
- Assert BTNU and BTNR in the same cycle -> two reads return 1 then 4.
- Hold io_addr=4096 for 3 cycles with queue {3,2} -> io_rdata=3 in all three cycles; count 2->1 once; the next separate access returns 2.
- Fill 4 events, then press BTNL twice more -> fifo_count=4, pending[2]=1. One read returns the head; BTNL is enqueued in that same cycle. With BTN_EVENT_STATUS_EN, a status read shows overflow=1, then 0 on the next status read.

Source files
------------

// File: rtl/button_event_port.sv
// button_event_port: debounced board buttons turned into press events, queued and returned one per processor load at IO_ADDR.
// Ports:
//   clock, reset      system clock; synchronous active-high reset
//   btn_in[3:0]       raw {BTNR, BTNL, BTND, BTNU}, asynchronous to clock
//   io_addr, io_wren  processor data address and store enable
//   io_hit            load decoded at the port (combinational)
//   io_rdata          event code on a data read (0 when the queue is empty), 0 when not hit
//   btn_level         debounced button levels
//   fifo_count        queued event count
// Optional: define BTN_EVENT_STATUS_EN to decode IO_ADDR+1 as a status read
//   {16'b0, overflow, 7'b0, fifo_count[3:0], btn_level}.
module button_event_port #(
    parameter int          DEBOUNCE_CYCLES = 250000,
    parameter int          FIFO_DEPTH      = 4,
    parameter logic [31:0] IO_ADDR         = 32'd4096
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [3:0]                    btn_in,
    input  logic [31:0]                   io_addr,
    input  logic                          io_wren,
    output logic                          io_hit,
    output logic [31:0]                   io_rdata,
    output logic [3:0]                    btn_level,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int            AW      = $clog2(FIFO_DEPTH);
    localparam int            CW      = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [AW:0]   FULL    = (AW + 1)'(FIFO_DEPTH);

    logic [3:0]    sync1, sync2, level_next, rise, pending, pending_next, grant;
    logic [CW-1:0] cnt [4];
    logic [CW-1:0] cnt_next [4];
    logic [2:0]    mem [FIFO_DEPTH];
    logic [2:0]    code;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count_next;
    logic [31:0]   hold, data_word, word;
    logic          hit_d, hit_data, acc_edge, empty, full, push, pop;

    always_comb begin
        level_next = btn_level;
        cnt_next   = cnt;
        for (int i = 0; i < 4; i++) begin
            level_next[i] = btn_level[i] ^ ((sync2[i] != btn_level[i]) && cnt[i] == CNT_MAX);
            cnt_next[i]   = (sync2[i] == btn_level[i] || cnt[i] == CNT_MAX) ? '0 : cnt[i] + 1'b1;
        end
    end

    assign rise  = level_next & ~btn_level;
    assign empty = fifo_count == '0;
    assign full  = fifo_count == FULL;

    // Lowest-index pending button wins; a full queue still accepts when the same cycle pops.
    assign grant        = pending & (~pending + 4'd1);
    assign push         = |pending && (!full || pop);
    assign pending_next = (pending & ~(push ? grant : 4'd0)) | rise;
    assign code         = grant[0] ? 3'd1 : grant[1] ? 3'd2 : grant[2] ? 3'd3 : 3'd4;

    assign hit_data  = io_addr == IO_ADDR && !io_wren;
    assign acc_edge  = io_hit && !hit_d;
    assign pop       = acc_edge && hit_data && !empty;
    assign data_word = empty ? 32'd0 : {29'd0, mem[rd_ptr]};
    assign count_next = (push && !pop) ? fifo_count + 1'b1 :
                        (pop && !push) ? fifo_count - 1'b1 : fifo_count;

`ifdef BTN_EVENT_STATUS_EN
    logic hit_stat, overflow, coalesce;
    assign hit_stat = io_addr == IO_ADDR + 32'd1 && !io_wren;
    assign io_hit   = hit_data || hit_stat;
    assign word     = hit_stat ? {16'd0, overflow, 7'd0, 4'(fifo_count), btn_level} : data_word;
    // A press whose pending bit survives this cycle is merged into the earlier one.
    assign coalesce = |(rise & pending & ~(push ? grant : 4'd0));
    always_ff @(posedge clock) begin
        if (reset) overflow <= 1'b0;
        else       overflow <= coalesce || (overflow && !(acc_edge && hit_stat));
    end
`else
    assign io_hit = hit_data;
    assign word   = data_word;
`endif

    // The access edge samples live data; stalled cycles of the same load replay the held word.
    assign io_rdata = (reset || !io_hit) ? 32'd0 : acc_edge ? word : hold;

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= code;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1      <= '0;
            sync2      <= '0;
            btn_level  <= '0;
            cnt        <= '{default: '0};
            pending    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            hold       <= '0;
            hit_d      <= 1'b0;
        end else begin
            sync1      <= btn_in;
            sync2      <= sync1;
            btn_level  <= level_next;
            cnt        <= cnt_next;
            pending    <= pending_next;
            wr_ptr     <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr     <= pop ? rd_ptr + 1'b1 : rd_ptr;
            fifo_count <= count_next;
            hold       <= acc_edge ? word : hold;
            hit_d      <= io_hit;
        end
    end
endmodule
